// File: rtl/rf_pkg.sv
// rf_pkg: register file geometry and the dump reader FSM state encoding
package rf_pkg;
   localparam int RF_AW = 5;
   localparam int RF_DW = 32;
   localparam int RF_NREGS = 32;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_OUT  = 2'd2,
      ST_DONE = 2'd3
   } dump_state_t;
endpackage

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: streams registers FIRST_REG..LAST_REG as (index, value) pairs over valid/ready
// RF_DUMP_SKIP_ZERO_EN: when defined, zero-valued registers are skipped instead of emitted
import rf_pkg::*;
module rf_dump_reader #(
   parameter int AW = RF_AW,
   parameter int DW = RF_DW,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG = 31
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_idx,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);
   localparam logic [AW-1:0] FIRST = AW'(FIRST_REG);
   localparam logic [AW-1:0] LAST = AW'(LAST_REG);
   dump_state_t state;
   logic [AW-1:0] idx;
   logic at_last;
   assign at_last = idx == LAST;
   assign rd_addr = idx;
   assign busy = state == ST_READ || state == ST_OUT;
   assign done = state == ST_DONE;
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         idx <= FIRST;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_idx <= '0;
         out_data <= '0;
      end else
         case (state)
            ST_IDLE:
               if (start) begin
                  idx <= FIRST;
                  state <= ST_READ;
               end
            ST_READ:
`ifdef RF_DUMP_SKIP_ZERO_EN
               if (rd_data == '0) begin
                  if (at_last) state <= ST_DONE;
                  else idx <= idx + AW'(1);
               end else
`endif
               begin
                  // value is snapshotted here; later RF writes do not reach the held entry
                  out_data <= rd_data;
                  out_idx <= idx;
                  out_last <= at_last;
                  out_valid <= 1'b1;
                  state <= ST_OUT;
               end
            ST_OUT:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (at_last) state <= ST_DONE;
                  else begin
                     idx <= idx + AW'(1);
                     state <= ST_READ;
                  end
               end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: directed checks of the register dump stream against a register file model
module tb_rf_dump_reader;
   import rf_pkg::*;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0, start1 = 1'b0;
   logic [RF_AW-1:0] rd_addr, out_idx, rd_addr1, out_idx1;
   logic [RF_DW-1:0] rd_data, out_data, rd_data1, out_data1;
   logic out_valid, out_last, busy, done, out_valid1, out_last1, busy1, done1;
   logic [RF_DW-1:0] rf [RF_NREGS];
   logic [RF_DW-1:0] exp_d [RF_NREGS];
   int tests = 0, fails = 0;
   int dc, fv;
   bit seen;
`ifdef RF_DUMP_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   rf_dump_reader dut (
      .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );
   rf_dump_reader #(.FIRST_REG(4), .LAST_REG(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .out_valid(out_valid1), .out_ready(1'b1), .out_idx(out_idx1), .out_data(out_data1),
      .out_last(out_last1), .busy(busy1), .done(done1)
   );
   assign rd_data = rf[rd_addr];
   assign rd_data1 = rf[rd_addr1];
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pat=1 accepts one cycle in three; restart_at pulses start once that many entries are taken;
   // wr5 overwrites x5 while entry 5 is being held
   task automatic dump(input string tag, input bit pat, input int restart_at, input bit wr5,
                       output int done_cyc, output int first_v);
      logic [4:0] gi[$];
      logic [31:0] gd[$];
      logic gl[$];
      logic [4:0] ei[$];
      logic [4:0] si;
      logic [31:0] sd;
      bit stalled;
      int acc_cyc;
      done_cyc = -1;
      first_v = -1;
      stalled = 1'b0;
      acc_cyc = -10;
      si = '0;
      sd = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         out_ready = pat ? (cyc % 3 == 0) : 1'b1;
         if (out_valid) begin
            if (first_v < 0) first_v = cyc;
            if (stalled) chk({tag, "_hold"}, 64'({out_idx, out_data}), 64'({si, sd}));
            if (wr5 && out_idx == 5'd5) rf[5] = 32'hDEAD_BEEF;
            if (restart_at >= 0 && gi.size() == restart_at) start = 1'b1;
            if (out_ready) begin
               gi.push_back(out_idx);
               gd.push_back(out_data);
               gl.push_back(out_last);
               acc_cyc = cyc;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               si = out_idx;
               sd = out_data;
            end
         end
         tick();
         start = 1'b0;
      end
      out_ready = 1'b0;
      chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
      if (!SKIP || exp_d[31] != 0) chk({tag, "_done_gap"}, 64'(done_cyc - acc_cyc), 64'(1));
      tick();
      chk({tag, "_done_pulse"}, 64'({done, busy}), 64'(0));
      for (int i = 1; i < 32; i++) if (!SKIP || exp_d[i] != 0) ei.push_back(5'(i));
      chk({tag, "_count"}, 64'(gi.size()), 64'(ei.size()));
      for (int k = 0; k < gi.size() && k < ei.size(); k++)
         chk({tag, "_entry"}, 64'({gi[k], gd[k], gl[k]}), 64'({ei[k], exp_d[ei[k]], ei[k] == 5'd31}));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf[i] = 32'(i * 'h11);
         exp_d[i] = rf[i];
      end
      tick();
      tick();
      chk("reset_outs", 64'({out_valid, out_last, busy, done}), 64'(0));
      chk("reset_idx_data", 64'({out_idx, out_data}), 64'(0));
      chk("reset_rd_addr", 64'(rd_addr), 64'(1));
      rst = 1'b0;
      tick();
      chk("idle_busy", 64'(busy), 64'(0));
      // full dump at full rate: first entry after two edges, done after 31 two-cycle entries
      dump("t1", 1'b0, -1, 1'b0, dc, fv);
      chk("t1_first_valid", 64'(fv), 64'(1));
      chk("t1_done_cyc", 64'(dc), 64'(62));
      // single-register range
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("one_busy", 64'({busy1, out_valid1}), 64'(2'b10));
      tick();
      chk("one_entry", 64'({out_valid1, out_last1, out_idx1, out_data1}), 64'({2'b11, 5'd4, 32'h44}));
      tick();
      chk("one_done", 64'({done1, out_valid1}), 64'(2'b10));
      tick();
      chk("one_idle", 64'({done1, busy1}), 64'(0));
      dump("t2", 1'b1, -1, 1'b0, dc, fv);
      dump("t3", 1'b0, 10, 1'b0, dc, fv);
      chk("t3_done_cyc", 64'(dc), 64'(62));
      dump("t3b", 1'b0, -1, 1'b0, dc, fv);
      dump("t5", 1'b0, -1, 1'b1, dc, fv);
      exp_d[5] = 32'hDEAD_BEEF;
      dump("t5b", 1'b0, -1, 1'b0, dc, fv);
      // abort mid-dump while entry 7 is held
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         out_ready = !(out_valid && out_idx == 5'd7);
         if (out_valid && out_idx == 5'd7) break;
         tick();
      end
      chk("t4_at7", 64'({out_valid, out_idx, out_data}), 64'({1'b1, 5'd7, 32'h77}));
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rst_outs", 64'({out_valid, out_last, busy, done}), 64'(0));
      chk("t4_rst_data", 64'({out_idx, out_data}), 64'(0));
      chk("t4_rst_addr", 64'(rd_addr), 64'(1));
      seen = 1'b0;
      repeat (5) begin
         tick();
         seen |= done;
      end
      chk("t4_no_done", 64'(seen), 64'(0));
      dump("t4b", 1'b0, -1, 1'b0, dc, fv);
      // start together with rst: reset wins
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_wins", 64'({busy, out_valid}), 64'(0));
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[3] = 32'h3;
      rf[31] = 32'h1F;
      for (int i = 0; i < 32; i++) exp_d[i] = rf[i];
      dump("t6", 1'b0, -1, 1'b0, dc, fv);
      rf[31] = '0;
      rf[10] = 32'hA;
      for (int i = 0; i < 32; i++) exp_d[i] = rf[i];
      dump("t6b", 1'b0, -1, 1'b0, dc, fv);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
